// File: rtl/rf_seq_pkg.sv
// Shared types for the 1RW register-file sequencer: FSM states, the read
// capture tag, and the address-width helper.
package rf_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    WB,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    CAP_NONE,
    CAP_RS1,
    CAP_RS2
  } cap_e;

  function automatic int unsigned raddr_width(input bit embedded);
    return embedded ? 4 : 5;
  endfunction

endpackage

// File: rtl/rf_1rw_sequencer.sv
// Serialises a dual-read/single-write regfile transaction onto a single-port
// synchronous RAM: reads first (so reads see pre-write values), then the write.
module rf_1rw_sequencer
  import rf_seq_pkg::*;
#(
  parameter bit embedded = 1'b1,
  localparam int unsigned raddr_w = raddr_width(embedded)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_rs1_en,
  input  logic [raddr_w-1:0] req_rs1,
  input  logic               req_rs2_en,
  input  logic [raddr_w-1:0] req_rs2,
  input  logic               req_rd_we,
  input  logic [raddr_w-1:0] req_rd,
  input  logic [31:0]        req_rd_data,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [31:0]        resp_rs1_data,
  output logic [31:0]        resp_rs2_data,
  output logic               mem_en,
  output logic               mem_we,
  output logic [raddr_w-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  state_e               state_q, state_d;
  cap_e                 cap_q, cap_d;
  logic                 rs1_en_q, rs2_en_q, rd_we_q;
  logic [raddr_w-1:0]   rs1_q, rs2_q, rd_q;
  logic [31:0]          rd_data_q;
  logic [31:0]          rs1_data_q, rs1_data_d;
  logic [31:0]          rs2_data_q, rs2_data_d;
  logic                 accept;

  // x0 never touches the RAM, so it never counts as a needed access.
  logic in_rs1_need, in_rs2_need, rs2_need, wr_need;
  assign in_rs1_need = req_rs1_en && (req_rs1 != '0);
  assign in_rs2_need = req_rs2_en && (req_rs2 != '0);
  assign rs2_need    = rs2_en_q && (rs2_q != '0);
  assign wr_need     = rd_we_q && (rd_q != '0);

  always_comb begin
    state_d    = state_q;
    cap_d      = CAP_NONE;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    accept     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    // RAM data arrives one cycle after the read strobe; the tag says where it goes.
    case (cap_q)
      CAP_RS1: rs1_data_d = mem_rdata;
      CAP_RS2: rs2_data_d = mem_rdata;
      default: ;
    endcase

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          rs1_data_d = '0;
          rs2_data_d = '0;
          if (in_rs1_need)      state_d = RD1;
          else if (in_rs2_need) state_d = RD2;
          else                  state_d = WB;
        end
      end
      RD1: begin
        mem_en   = 1'b1;
        mem_addr = rs1_q;
        cap_d    = CAP_RS1;
        state_d  = rs2_need ? RD2 : WB;
      end
      RD2: begin
        mem_en   = 1'b1;
        mem_addr = rs2_q;
        cap_d    = CAP_RS2;
        state_d  = WB;
      end
      WB: begin
        if (wr_need) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = rd_q;
          mem_wdata = rd_data_q;
        end
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cap_q      <= CAP_NONE;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_en_q  <= 1'b0;
      rs1_q     <= '0;
      rs2_en_q  <= 1'b0;
      rs2_q     <= '0;
      rd_we_q   <= 1'b0;
      rd_q      <= '0;
      rd_data_q <= '0;
    end else if (accept) begin
      rs1_en_q  <= req_rs1_en;
      rs1_q     <= req_rs1;
      rs2_en_q  <= req_rs2_en;
      rs2_q     <= req_rs2;
      rd_we_q   <= req_rd_we;
      rd_q      <= req_rd;
      rd_data_q <= req_rd_data;
    end
  end

  assign resp_rs1_data = rs1_data_q;
  assign resp_rs2_data = rs2_data_q;

endmodule

// File: tb/tb_rf_1rw_sequencer.sv
// Bench for rf_1rw_sequencer: a 1RW RAM with 1-cycle read latency behind the
// DUT, and a plain array model of the architectural register file.
module tb_rf_1rw_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rs1_en = 1'b0;
  logic [3:0]  req_rs1 = '0;
  logic        req_rs2_en = 1'b0;
  logic [3:0]  req_rs2 = '0;
  logic        req_rd_we = 1'b0;
  logic [3:0]  req_rd = '0;
  logic [31:0] req_rd_data = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rs1_data;
  logic [31:0] resp_rs2_data;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram [16];
  logic [31:0] ramRdata = '0;
  logic [31:0] model [16];

  int nAsserts = 0;
  int nFail = 0;

  rf_1rw_sequencer #(.embedded(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1_en(req_rs1_en), .req_rs1(req_rs1),
    .req_rs2_en(req_rs2_en), .req_rs2(req_rs2),
    .req_rd_we(req_rd_we), .req_rd(req_rd), .req_rd_data(req_rd_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rs1_data(resp_rs1_data), .resp_rs2_data(resp_rs2_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM: write-or-read per strobe, read data registered.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ramRdata <= ram[mem_addr];
    end
  end
  assign mem_rdata = ramRdata;

  // One full transaction checked against the architectural model.
  task automatic applyStimulus(input bit r1En, input logic [3:0] r1,
                               input bit r2En, input logic [3:0] r2,
                               input bit we, input logic [3:0] rd,
                               input logic [31:0] data, input int holdCycles);
    logic [31:0] exp1, exp2;
    logic [3:0]  expAddr [$];
    int nReads, wNeed, lat, seenR, seenW, readErr, writeErr, holdErr;
    bit found;
    exp1 = (r1En && r1 != 0) ? model[r1] : 32'h0;
    exp2 = (r2En && r2 != 0) ? model[r2] : 32'h0;
    nReads = 0;
    if (r1En && r1 != 0) begin nReads++; expAddr.push_back(r1); end
    if (r2En && r2 != 0) begin nReads++; expAddr.push_back(r2); end
    wNeed = (we && rd != 0) ? 1 : 0;
    seenR = 0; seenW = 0; readErr = 0; writeErr = 0; holdErr = 0;
    lat = 0; found = 1'b0;

    @(negedge clk);
    nAsserts++;
    if (req_ready !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL req_ready_idle: got %b want 1", req_ready);
    end
    req_rs1_en = r1En; req_rs1 = r1; req_rs2_en = r2En; req_rs2 = r2;
    req_rd_we = we; req_rd = rd; req_rd_data = data; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clk);
      if (resp_valid === 1'b1) begin
        lat = c; found = 1'b1;
        break;
      end
      if (req_ready !== 1'b0) holdErr++;
      if (mem_en === 1'b1 && mem_we === 1'b0) begin
        seenR++;
        if (expAddr.size() == 0) readErr++;
        else if (mem_addr !== expAddr.pop_front()) readErr++;
      end
      if (mem_en === 1'b1 && mem_we === 1'b1) begin
        seenW++;
        if (mem_addr !== rd || mem_wdata !== data) writeErr++;
      end
    end

    nAsserts++;
    if (!found) begin
      nFail++;
      $display("[TB] FAIL resp_timeout: resp_valid never rose within 8 cycles, want %0d", 2 + nReads);
      return;
    end
    nAsserts++;
    if (lat != 2 + nReads) begin
      nFail++;
      $display("[TB] FAIL latency: got %0d want %0d", lat, 2 + nReads);
    end
    nAsserts++;
    if (seenR != nReads || readErr != 0) begin
      nFail++;
      $display("[TB] FAIL mem_reads: got %0d (bad addr %0d) want %0d", seenR, readErr, nReads);
    end
    nAsserts++;
    if (seenW != wNeed || writeErr != 0) begin
      nFail++;
      $display("[TB] FAIL mem_writes: got %0d (bad %0d) want %0d", seenW, writeErr, wNeed);
    end
    nAsserts++;
    if (resp_rs1_data !== exp1) begin
      nFail++;
      $display("[TB] FAIL rs1_data: got %h want %h", resp_rs1_data, exp1);
    end
    nAsserts++;
    if (resp_rs2_data !== exp2) begin
      nFail++;
      $display("[TB] FAIL rs2_data: got %h want %h", resp_rs2_data, exp2);
    end

    for (int h = 0; h < holdCycles; h++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rs1_data !== exp1 || resp_rs2_data !== exp2 ||
          req_ready !== 1'b0 || mem_en !== 1'b0) holdErr++;
    end
    nAsserts++;
    if (holdErr != 0) begin
      nFail++;
      $display("[TB] FAIL resp_hold: got %0d unstable cycles want 0", holdErr);
    end

    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    nAsserts++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL back_to_idle: req_ready=%b resp_valid=%b want 1/0", req_ready, resp_valid);
    end
    if (wNeed != 0) model[rd] = data;
  endtask

  task automatic test_reset();
    #3;
    nAsserts++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_en !== 1'b0 || mem_we !== 1'b0 ||
        mem_addr !== 4'h0 || mem_wdata !== 32'h0 ||
        resp_rs1_data !== 32'h0 || resp_rs2_data !== 32'h0) begin
      nFail++;
      $display("[TB] FAIL reset_outputs: rdy=%b rv=%b en=%b we=%b addr=%h wd=%h d1=%h d2=%h want 1/0/0/0/0/0/0/0",
               req_ready, resp_valid, mem_en, mem_we, mem_addr, mem_wdata, resp_rs1_data, resp_rs2_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_then_read();
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd5, 32'hDEADBEEF, 0);
    applyStimulus(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 32'h0, 0);
  endtask

  task automatic test_same_regs();
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd3, 32'h11, 0);
    applyStimulus(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd3, 32'h22, 0);
    applyStimulus(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 0);
  endtask

  task automatic test_x0();
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd0, 32'hFFFFFFFF, 0);
    applyStimulus(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd0, 32'h0, 0);
  endtask

  task automatic test_resp_hold();
    applyStimulus(1'b1, 4'd5, 1'b1, 4'd3, 1'b1, 4'd9, 32'hA5A5_0001, 5);
  endtask

  task automatic test_reset_mid_write();
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd7, 32'h01, 0);
    @(negedge clk);
    req_rs1_en = 1'b0; req_rs2_en = 1'b0;
    req_rd_we = 1'b1; req_rd = 4'd7; req_rd_data = 32'h55; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    nAsserts++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 4'd7) begin
      nFail++;
      $display("[TB] FAIL wb_write_strobe: en=%b we=%b addr=%h want 1/1/7", mem_en, mem_we, mem_addr);
    end
    rst_n = 1'b0;
    #1;
    nAsserts++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL async_reset_abort: en=%b we=%b rdy=%b rv=%b want 0/0/1/0",
               mem_en, mem_we, req_ready, resp_valid);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                    $urandom(), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i] = 32'h0;
      model[i] = 32'h0;
    end
    test_reset();
    test_write_then_read();
    test_same_regs();
    test_x0();
    test_resp_hold();
    test_reset_mid_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
